// File: rtl/cmd_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : cmd_pkg
// Brief  : Shared constants, state enum and opcode decode for cmd_frame_parser.
// Rev    : 1.0
// ----------------------------------------------------------------------------
package cmd_pkg;

  localparam logic [7:0]  c_SYNC_BYTE  = 8'hA5;

  localparam logic [7:0]  c_OP_FREQ    = 8'h01;
  localparam logic [7:0]  c_OP_AMP     = 8'h02;
  localparam logic [7:0]  c_OP_PHASE   = 8'h03;
  localparam logic [7:0]  c_OP_WAVE    = 8'h04;

  localparam logic [1:0]  c_ID_FREQ    = 2'd0;
  localparam logic [1:0]  c_ID_AMP     = 2'd1;
  localparam logic [1:0]  c_ID_PHASE   = 2'd2;
  localparam logic [1:0]  c_ID_WAVE    = 2'd3;

  localparam logic [13:0] c_AMP_RESET  = 14'h3FFF;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_GET_CMD = 3'd1,
    S_GET_PAY = 3'd2,
    S_GET_CHK = 3'd3,
    S_APPLY   = 3'd4
  } state_t;

  // Returns {valid, cfg_id}; valid is low for unknown opcodes.
  function automatic logic [2:0] op_decode(input logic [7:0] op);
    case (op)
      c_OP_FREQ:  return {1'b1, c_ID_FREQ};
      c_OP_AMP:   return {1'b1, c_ID_AMP};
      c_OP_PHASE: return {1'b1, c_ID_PHASE};
      c_OP_WAVE:  return {1'b1, c_ID_WAVE};
      default:    return 3'b000;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/cmd_gap_timer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : cmd_gap_timer
// Brief  : Counts idle clocks between bytes of a frame; expire when the gap limit is hit.
// Rev    : 1.0
// ----------------------------------------------------------------------------
module cmd_gap_timer #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_run,
  output logic o_expire
);

  localparam int             CW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0]  c_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || i_clear || !i_run) begin
      r_cnt <= '0;
    end else if (r_cnt != c_LAST) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // A byte in the expiry cycle clears the counter instead of expiring.
  assign o_expire = i_run && !i_clear && (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/cmd_frame_parser.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : cmd_frame_parser
// Brief  : Assembles USB byte strobes into framed generator commands; CMD_CHECKSUM_EN adds a CHK byte.
// Rev    : 1.0
// ----------------------------------------------------------------------------
module cmd_frame_parser
  import cmd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic [31:0] o_freq_word,
  output logic [13:0] o_amp_word,
  output logic [15:0] o_phase_word,
  output logic [1:0]  o_wave_sel,
  output logic        o_cfg_upd,
  output logic [1:0]  o_cfg_id,
  output logic        o_frame_err
);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_cnt;
  logic [7:0]  r_cmd;
  logic [31:0] r_pay;
`ifdef CMD_CHECKSUM_EN
  logic [7:0]  r_xor;
`endif

  logic        w_take;
  logic        w_run;
  logic        w_expire;
  logic        w_upd;
  logic        w_err;
  logic [1:0]  w_id;
  logic [2:0]  w_dec;

  assign w_take = i_rx_valid && (r_state != S_APPLY);
  assign w_run  = (r_state != S_IDLE) && (r_state != S_APPLY);
  assign w_dec  = op_decode(r_cmd);

  cmd_gap_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_gap_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (w_take),
    .i_run    (w_run),
    .o_expire (w_expire)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_upd       = 1'b0;
    w_err       = 1'b0;
    w_id        = w_dec[1:0];
    case (r_state)
      S_IDLE: begin
        if (w_take && (i_rx_data == c_SYNC_BYTE)) w_state_nxt = S_GET_CMD;
      end
      S_GET_CMD: begin
        if (w_take) begin
          w_state_nxt = S_GET_PAY;
        end else if (w_expire) begin
          w_state_nxt = S_IDLE;
          w_err       = 1'b1;
        end
      end
      S_GET_PAY: begin
        if (w_take) begin
`ifdef CMD_CHECKSUM_EN
          if (r_cnt == 2'd0) w_state_nxt = S_GET_CHK;
`else
          if (r_cnt == 2'd0) w_state_nxt = S_APPLY;
`endif
        end else if (w_expire) begin
          w_state_nxt = S_IDLE;
          w_err       = 1'b1;
        end
      end
`ifdef CMD_CHECKSUM_EN
      S_GET_CHK: begin
        if (w_take) begin
          w_state_nxt = (i_rx_data == r_xor) ? S_APPLY : S_IDLE;
          w_err       = (i_rx_data != r_xor);
        end else if (w_expire) begin
          w_state_nxt = S_IDLE;
          w_err       = 1'b1;
        end
      end
`endif
      S_APPLY: begin
        w_state_nxt = S_IDLE;
        w_upd       = w_dec[2];
        w_err       = !w_dec[2];
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt        <= 2'd0;
      r_cmd        <= 8'd0;
      r_pay        <= 32'd0;
`ifdef CMD_CHECKSUM_EN
      r_xor        <= 8'd0;
`endif
      o_freq_word  <= 32'd0;
      o_amp_word   <= c_AMP_RESET;
      o_phase_word <= 16'd0;
      o_wave_sel   <= 2'd0;
      o_cfg_upd    <= 1'b0;
      o_cfg_id     <= 2'd0;
      o_frame_err  <= 1'b0;
    end else begin
      o_cfg_upd   <= w_upd;
      o_frame_err <= w_err;
      if (w_take && (r_state == S_GET_CMD)) begin
        r_cmd <= i_rx_data;
        r_cnt <= 2'd3;
`ifdef CMD_CHECKSUM_EN
        r_xor <= i_rx_data;
`endif
      end
      if (w_take && (r_state == S_GET_PAY)) begin
        r_pay <= {r_pay[23:0], i_rx_data};
        r_cnt <= r_cnt - 2'd1;
`ifdef CMD_CHECKSUM_EN
        r_xor <= r_xor ^ i_rx_data;
`endif
      end
      // Holding register and cfg_upd move on the same edge.
      if (w_upd) begin
        o_cfg_id <= w_id;
        case (w_id)
          c_ID_FREQ:  o_freq_word  <= r_pay;
          c_ID_AMP:   o_amp_word   <= r_pay[13:0];
          c_ID_PHASE: o_phase_word <= r_pay[15:0];
          default:    o_wave_sel   <= r_pay[1:0];
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cmd_frame_parser.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : tb_cmd_frame_parser
// Brief  : Self-checking bench for cmd_frame_parser; honours CMD_CHECKSUM_EN.
// Rev    : 1.0
// ----------------------------------------------------------------------------
module tb_cmd_frame_parser;

  localparam int TO = 16;
`ifdef CMD_CHECKSUM_EN
  localparam int FRAME_LEN = 7;
`else
  localparam int FRAME_LEN = 6;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [31:0] freq_word;
  logic [13:0] amp_word;
  logic [15:0] phase_word;
  logic [1:0]  wave_sel;
  logic        cfg_upd;
  logic [1:0]  cfg_id;
  logic        frame_err;

  cmd_frame_parser #(.TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_rx_data    (rx_data),
    .i_rx_valid   (rx_valid),
    .o_freq_word  (freq_word),
    .o_amp_word   (amp_word),
    .o_phase_word (phase_word),
    .o_wave_sel   (wave_sel),
    .o_cfg_upd    (cfg_upd),
    .o_cfg_id     (cfg_id),
    .o_frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int n_upd = 0;
  int n_err = 0;
  int n_both = 0;
  logic [1:0] last_id = 2'd0;

  always @(negedge clk) begin
    if (cfg_upd) begin
      n_upd   <= n_upd + 1;
      last_id <= cfg_id;
    end
    if (frame_err) n_err <= n_err + 1;
    if (cfg_upd && frame_err) n_both <= n_both + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  // Sends the first n bytes of a frame with 'gap' idle clocks between bytes.
  task automatic send_bytes(input logic [7:0] cmd, input logic [31:0] pay, input bit bad,
                            input int gap, input int n);
    logic [7:0] b [7];
    b[0] = 8'hA5;
    b[1] = cmd;
    b[2] = pay[31:24];
    b[3] = pay[23:16];
    b[4] = pay[15:8];
    b[5] = pay[7:0];
    b[6] = cmd ^ pay[31:24] ^ pay[23:16] ^ pay[15:8] ^ pay[7:0] ^ (bad ? 8'h5C : 8'h00);
    for (int i = 0; i < n; i++) begin
      if (i > 0) idle(gap);
      send_byte(b[i]);
    end
  endtask

  typedef struct {
    logic [7:0]  cmd;
    logic [31:0] pay;
    bit          bad;
    bit          e_upd;
    logic [1:0]  e_id;
    bit          e_err;
    logic [31:0] e_freq;
    logic [13:0] e_amp;
    logic [15:0] e_phase;
    logic [1:0]  e_wave;
  } vec_t;

  vec_t tbl[$];

  logic [31:0] m_freq;
  logic [13:0] m_amp;
  logic [15:0] m_phase;
  logic [1:0]  m_wave;

  task automatic chk_regs(input string tag);
    chk({tag, ".freq"},  freq_word,  m_freq);
    chk({tag, ".amp"},   32'(amp_word),   32'(m_amp));
    chk({tag, ".phase"}, 32'(phase_word), 32'(m_phase));
    chk({tag, ".wave"},  32'(wave_sel),   32'(m_wave));
  endtask

  initial begin
    int n0u, n0e;
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    idle(3);
    rst_n = 1'b1;
    tick();
    m_freq = 32'd0; m_amp = 14'h3FFF; m_phase = 16'd0; m_wave = 2'd0;
    chk_regs("reset");
    chk("reset.cfg_upd", 32'(cfg_upd), 0);
    chk("reset.cfg_id", 32'(cfg_id), 0);
    chk("reset.frame_err", 32'(frame_err), 0);

    // ---- table-driven frames (expected state is cumulative) ----
    tbl.push_back('{8'h01, 32'h12345678, 0, 1, 2'd0, 0, 32'h12345678, 14'h3FFF, 16'h0000, 2'd0});
    tbl.push_back('{8'h02, 32'h0000FFFF, 0, 1, 2'd1, 0, 32'h12345678, 14'h3FFF, 16'h0000, 2'd0});
    tbl.push_back('{8'h02, 32'hABCD5555, 0, 1, 2'd1, 0, 32'h12345678, 14'h1555, 16'h0000, 2'd0});
    tbl.push_back('{8'h04, 32'h00000002, 0, 1, 2'd3, 0, 32'h12345678, 14'h1555, 16'h0000, 2'd2});
    tbl.push_back('{8'h03, 32'h1234BEEF, 0, 1, 2'd2, 0, 32'h12345678, 14'h1555, 16'hBEEF, 2'd2});
    tbl.push_back('{8'h09, 32'h00000000, 0, 0, 2'd0, 1, 32'h12345678, 14'h1555, 16'hBEEF, 2'd2});
`ifdef CMD_CHECKSUM_EN
    tbl.push_back('{8'h01, 32'hDEADBEEF, 1, 0, 2'd0, 1, 32'h12345678, 14'h1555, 16'hBEEF, 2'd2});
`endif
    tbl.push_back('{8'h00, 32'hFFFFFFFF, 0, 0, 2'd0, 1, 32'h12345678, 14'h1555, 16'hBEEF, 2'd2});
    tbl.push_back('{8'h04, 32'hFFFFFFFD, 0, 1, 2'd3, 0, 32'h12345678, 14'h1555, 16'hBEEF, 2'd1});
    tbl.push_back('{8'h01, 32'h00000010, 0, 1, 2'd0, 0, 32'h00000010, 14'h1555, 16'hBEEF, 2'd1});

    foreach (tbl[i]) begin
      n0u = n_upd; n0e = n_err;
      send_bytes(tbl[i].cmd, tbl[i].pay, tbl[i].bad, 1, FRAME_LEN);
      chk($sformatf("tbl%0d.upd_early", i), 32'(cfg_upd), 0);
      tick();
      chk($sformatf("tbl%0d.upd", i), 32'(cfg_upd), 32'(tbl[i].e_upd));
      if (tbl[i].e_upd) chk($sformatf("tbl%0d.id", i), 32'(cfg_id), 32'(tbl[i].e_id));
      tick();
      chk($sformatf("tbl%0d.upd_pulse", i), 32'(cfg_upd), 0);
      m_freq = tbl[i].e_freq; m_amp = tbl[i].e_amp; m_phase = tbl[i].e_phase; m_wave = tbl[i].e_wave;
      chk_regs($sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d.n_upd", i), 32'(n_upd - n0u), 32'(tbl[i].e_upd));
      chk($sformatf("tbl%0d.n_err", i), 32'(n_err - n0e), 32'(tbl[i].e_err));
    end

    // ---- garbage before a valid frame ----
    n0u = n_upd; n0e = n_err;
    send_byte(8'h00); idle(1);
    send_byte(8'hFF); idle(1);
    send_byte(8'h5A); idle(1);
    send_bytes(8'h03, 32'h0000CAFE, 0, 1, FRAME_LEN);
    idle(2);
    m_phase = 16'hCAFE;
    chk_regs("garbage");
    chk("garbage.n_err", 32'(n_err - n0e), 0);
    chk("garbage.n_upd", 32'(n_upd - n0u), 1);

    // ---- timeout mid-frame, leftover bytes ignored, then a full frame ----
    n0u = n_upd; n0e = n_err;
    send_bytes(8'h03, 32'h0000BEEF, 0, 1, 3);
    idle(TO - 1);
    chk("timeout.early", 32'(frame_err), 0);
    tick();
    chk("timeout.err", 32'(frame_err), 1);
    idle(2);
    send_byte(8'h00); idle(1);
    send_byte(8'hBE); idle(1);
    send_byte(8'hEF); idle(2);
    chk("timeout.phase_kept", 32'(phase_word), 32'(m_phase));
    chk("timeout.n_upd", 32'(n_upd - n0u), 0);
    chk("timeout.n_err", 32'(n_err - n0e), 1);
    send_bytes(8'h03, 32'h0000BEEF, 0, 1, FRAME_LEN);
    idle(2);
    m_phase = 16'hBEEF;
    chk_regs("after_timeout");

    // ---- every byte arrives exactly in the expiry cycle ----
    n0u = n_upd; n0e = n_err;
    send_bytes(8'h01, 32'hCAFEF00D, 0, TO - 1, FRAME_LEN);
    idle(2);
    m_freq = 32'hCAFEF00D;
    chk_regs("expiry_edge");
    chk("expiry_edge.n_err", 32'(n_err - n0e), 0);
    chk("expiry_edge.n_upd", 32'(n_upd - n0u), 1);

    // ---- reset during P2 ----
    n0e = n_err;
    send_bytes(8'h01, 32'h11223344, 0, 1, 3);
    idle(1);
    rx_data = 8'h22; rx_valid = 1'b1; rst_n = 1'b0;
    tick();
    rx_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    m_freq = 32'd0; m_amp = 14'h3FFF; m_phase = 16'd0; m_wave = 2'd0;
    chk_regs("midreset");
    chk("midreset.cfg_upd", 32'(cfg_upd), 0);
    chk("midreset.cfg_id", 32'(cfg_id), 0);
    chk("midreset.n_err", 32'(n_err - n0e), 0);
    send_byte(8'h33); idle(1);
    send_byte(8'h44); idle(1);
    send_bytes(8'h01, 32'h0BADF00D, 0, 1, FRAME_LEN);
    idle(2);
    m_freq = 32'h0BADF00D;
    chk_regs("post_reset");

    // ---- randomized frames against the reference model ----
    for (int it = 0; it < 150; it++) begin
      logic [7:0]  cmd, g;
      logic [31:0] pay;
      bit          bad, to, e_upd, e_err;
      logic [1:0]  e_id;
      int          gap, k;
      for (int j = $urandom_range(0, 2); j > 0; j--) begin
        do g = 8'($urandom); while (g == 8'hA5);
        send_byte(g); idle(1);
      end
      case ($urandom_range(0, 5))
        0: cmd = 8'h01;
        1: cmd = 8'h02;
        2: cmd = 8'h03;
        3: cmd = 8'h04;
        default: cmd = 8'($urandom);
      endcase
      pay = $urandom;
      bad = 1'b0;
`ifdef CMD_CHECKSUM_EN
      bad = ($urandom_range(0, 7) == 0);
`endif
      to  = ($urandom_range(0, 9) == 0);
      gap = $urandom_range(1, TO - 1);
      n0u = n_upd; n0e = n_err;
      e_upd = 1'b0; e_err = 1'b0; e_id = 2'd0;
      if (to) begin
        k = $urandom_range(1, FRAME_LEN - 1);
        send_bytes(cmd, pay, bad, gap, k);
        idle(TO + 1);
        e_err = 1'b1;
      end else begin
        send_bytes(cmd, pay, bad, gap, FRAME_LEN);
        idle(2);
        if (bad) e_err = 1'b1;
        else begin
          case (cmd)
            8'h01: begin m_freq  = pay;        e_upd = 1'b1; e_id = 2'd0; end
            8'h02: begin m_amp   = pay[13:0];  e_upd = 1'b1; e_id = 2'd1; end
            8'h03: begin m_phase = pay[15:0];  e_upd = 1'b1; e_id = 2'd2; end
            8'h04: begin m_wave  = pay[1:0];   e_upd = 1'b1; e_id = 2'd3; end
            default: e_err = 1'b1;
          endcase
        end
      end
      chk_regs($sformatf("rnd%0d", it));
      chk($sformatf("rnd%0d.n_upd", it), 32'(n_upd - n0u), 32'(e_upd));
      chk($sformatf("rnd%0d.n_err", it), 32'(n_err - n0e), 32'(e_err));
      if (e_upd) chk($sformatf("rnd%0d.id", it), 32'(last_id), 32'(e_id));
    end

    chk("upd_err_exclusive", 32'(n_both), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
